// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC sequencing controller and its datapath.
package mac_pkg;
  localparam int MAC_LAT   = 3;
  localparam int DEF_WIDTH = 16;
  localparam int DRAIN_W   = $clog2(MAC_LAT + 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } state_t;
endpackage

// File: rtl/mac.sv
// Pipelined signed multiply-accumulate: product, accumulate and output stages (latency MAC_LAT).
// Synchronous active-low clear on rstb; results wrap at WIDTH bits.
module mac #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out
);
  logic [WIDTH-1:0] prod_w;
  logic [WIDTH-1:0] prod_q;
  logic [WIDTH-1:0] acc_q;

  // Low WIDTH bits of a two's-complement product are sign-agnostic.
  assign prod_w = a * b;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      prod_q <= '0;
      acc_q  <= '0;
      out    <= '0;
    end else begin
      prod_q <= prod_w;
      acc_q  <= acc_q + prod_q;
      out    <= acc_q;
    end
  end
endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequences one dot-product job through the pipelined mac: clear, stream, drain, hold result.
// Optional performance counters are enabled with `define MAC_SEQ_CTRL_PERF_EN.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef MAC_SEQ_CTRL_PERF_EN
  output logic [15:0]      stall_cnt,
  output logic [15:0]      job_cycles,
`endif
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] mac_a,
  output logic [WIDTH-1:0] mac_b,
  output logic             mac_rstb,
  input  logic [WIDTH-1:0] mac_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data
);
  state_t             state;
  logic [LEN_W-1:0]   rem;
  logic [DRAIN_W-1:0] drain;
  logic               xfer;

  assign busy      = (state != IDLE);
  assign in_ready  = (state == STREAM);
  assign res_valid = (state == DONE);
  assign xfer      = (state == STREAM) && in_valid;

  // Bubbles and drain feed zero products so the accumulator is untouched.
  assign mac_a = xfer ? in_a : '0;
  assign mac_b = xfer ? in_b : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rem      <= '0;
      drain    <= '0;
      res_data <= '0;
      mac_rstb <= 1'b0;
    end else begin
      mac_rstb <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            rem      <= len;
            mac_rstb <= 1'b0;
            state    <= CLEAR;
          end
        end
        CLEAR: begin
          if (rem == '0) begin
            drain <= DRAIN_W'(MAC_LAT);
            state <= DRAIN;
          end else begin
            state <= STREAM;
          end
        end
        STREAM: begin
          if (in_valid) begin
            rem <= rem - 1'b1;
            if (rem == LEN_W'(1)) begin
              drain <= DRAIN_W'(MAC_LAT);
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          drain <= drain - 1'b1;
          if (drain == DRAIN_W'(1)) begin
            res_data <= mac_out;
            state    <= DONE;
          end
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MAC_SEQ_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) begin
      stall_cnt  <= '0;
      job_cycles <= '0;
    end else begin
      if ((state == CLEAR || state == STREAM || state == DRAIN) && job_cycles != '1)
        job_cycles <= job_cycles + 1'b1;
      if (state == STREAM && !in_valid && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl driving a real mac; covers MAC_SEQ_CTRL_PERF_EN when defined.
module tb_mac_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic        mac_rstb;
  logic [15:0] mac_out;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
`ifdef MAC_SEQ_CTRL_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] job_cycles;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int qa[$];
  int qb[$];

  mac_seq_ctrl #(.WIDTH(16), .LEN_W(8)) dut (
    .clk(clk), .rst(rst),
`ifdef MAC_SEQ_CTRL_PERF_EN
    .stall_cnt(stall_cnt), .job_cycles(job_cycles),
`endif
    .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_rstb(mac_rstb), .mac_out(mac_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  mac #(.WIDTH(16)) u_mac (
    .clk(clk), .rstb(mac_rstb), .a(mac_a), .b(mac_b), .out(mac_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int a, input int b);
    qa.push_back(a);
    qb.push_back(b);
  endtask

  // bub: 0 back-to-back, 1 two idle cycles before every pair after the first, 2 random.
  task automatic run_job(input int n, input int bub, input int hold, output logic [15:0] got);
    int s, idx, last_k, gap, stalls, cyc_done;
    bit seen, go;
    longint acc;
    logic [15:0] expv;
    logic [15:0] ea, eb;
    acc = 0;
    for (int i = 0; i < n; i++) acc += longint'(qa[i]) * longint'(qb[i]);
    expv = acc[15:0];

    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 0);
    start = 1'b1;
    len   = 8'(n);
    s     = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("clear_busy", {31'd0, busy}, 1);
    chk("clear_rstb", {31'd0, mac_rstb}, 0);
    chk("clear_in_ready", {31'd0, in_ready}, 0);

    idx = 0; last_k = s; gap = 2; stalls = 0; seen = 0; cyc_done = 0;
    for (int t = 0; t < 400 && !seen; t++) begin
      @(negedge clk);
      if (res_valid) begin
        seen = 1;
        cyc_done = cyc;
      end else begin
        chk("in_ready", {31'd0, in_ready}, (idx < n) ? 1 : 0);
        if (idx < n) begin
          go = (bub == 0) || (bub == 1 && gap >= 2) || (bub == 2 && $urandom_range(1, 0) == 1);
          in_valid = go;
          in_a = go ? 16'(qa[idx]) : 16'($urandom);
          in_b = go ? 16'(qb[idx]) : 16'($urandom);
        end else begin
          go = 0;
          in_valid = 1'($urandom_range(1, 0));
          in_a = 16'($urandom);
          in_b = 16'($urandom);
        end
        ea = go ? in_a : 16'd0;
        eb = go ? in_b : 16'd0;
        #1;
        chk("mac_a", {16'd0, mac_a}, {16'd0, ea});
        chk("mac_b", {16'd0, mac_b}, {16'd0, eb});
        if (go) begin
          idx++; last_k = cyc; gap = 0;
        end else if (idx < n) begin
          gap++; stalls++;
        end
      end
    end
    in_valid = 1'b0;
    chk("res_seen", {31'd0, seen}, 1);
    chk("xfers", 32'(idx), 32'(n));
    chk("latency", 32'(cyc_done), (n == 0) ? 32'(s + 5) : 32'(last_k + 4));
    chk("res_data", {16'd0, res_data}, {16'd0, expv});
`ifdef MAC_SEQ_CTRL_PERF_EN
    chk("stall_cnt", {16'd0, stall_cnt}, 32'(stalls));
    chk("job_cycles", {16'd0, job_cycles}, 32'(cyc_done - s - 1));
`endif
    got = res_data;

    // Stay in DONE for `hold` cycles with disruptive start/in_valid activity.
    res_ready = (hold == 0);
    start = 1'b1;
    for (int h = 1; h <= hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, res_valid}, 1);
      chk("hold_data", {16'd0, res_data}, {16'd0, expv});
      chk("hold_busy", {31'd0, busy}, 1);
      chk("hold_in_ready", {31'd0, in_ready}, 0);
`ifdef MAC_SEQ_CTRL_PERF_EN
      chk("hold_stall", {16'd0, stall_cnt}, 32'(stalls));
      chk("hold_jobcyc", {16'd0, job_cycles}, 32'(cyc_done - s - 1));
`endif
      res_ready = (h == hold);
      start = 1'b1;
      in_valid = 1'(h % 2);
      in_a = 16'($urandom);
      in_b = 16'($urandom);
      #1;
      chk("hold_mac_a", {16'd0, mac_a}, 0);
    end
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    chk("post_valid", {31'd0, res_valid}, 0);
    chk("post_busy", {31'd0, busy}, 0);
    @(negedge clk);
    chk("no_new_job", {31'd0, busy}, 0);
  endtask

  logic [15:0] r;

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_res_valid", {31'd0, res_valid}, 0);
    chk("rst_res_data", {16'd0, res_data}, 0);
    chk("rst_mac_rstb", {31'd0, mac_rstb}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_rstb", {31'd0, mac_rstb}, 1);

    // 1: back-to-back pairs
    qa.delete(); qb.delete();
    push(2, 3); push(4, 5); push(-1, 6);
    run_job(3, 0, 0, r);
    chk("t1_value", {16'd0, r}, 20);

    // 2: bubbles between pairs
    run_job(3, 1, 0, r);
    chk("t2_value", {16'd0, r}, 20);

    // 3: empty job
    qa.delete(); qb.delete();
    run_job(0, 0, 0, r);
    chk("t3_value", {16'd0, r}, 0);

    // 4: result held under back-pressure
    qa.delete(); qb.delete();
    push(2, 3); push(4, 5); push(-1, 6);
    run_job(3, 0, 5, r);
    chk("t4_value", {16'd0, r}, 20);

    // 5: reset after one of three pairs, then a fresh job
    @(negedge clk);
    start = 1'b1; len = 8'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_a = 16'd2; in_b = 16'd3;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_in_ready", {31'd0, in_ready}, 0);
    chk("abort_res_valid", {31'd0, res_valid}, 0);
    chk("abort_mac_rstb", {31'd0, mac_rstb}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rstb_back", {31'd0, mac_rstb}, 1);
    qa.delete(); qb.delete();
    push(3, 3); push(1, -1);
    run_job(2, 0, 1, r);
    chk("t5_value", {16'd0, r}, 8);

    // 6: consecutive single-pair jobs
    qa.delete(); qb.delete();
    push(7, 7);
    run_job(1, 0, 0, r);
    chk("t6_first", {16'd0, r}, 49);
    qa.delete(); qb.delete();
    push(-2, 5);
    run_job(1, 0, 0, r);
    chk("t6_second", {16'd0, r}, 32'hFFF6);

    // Randomized jobs with full-range operands, wrapping arithmetic and random bubbles
    for (int j = 0; j < 8; j++) begin
      int n;
      n = $urandom_range(10, 1);
      qa.delete(); qb.delete();
      for (int i = 0; i < n; i++)
        push(int'($signed(16'($urandom))), int'($signed(16'($urandom))));
      run_job(n, 2, $urandom_range(3, 0), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
